// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_pkg
// Description : Shared definitions for the SRAM port arbiter: FSM state
//               encoding, SRAM strobe active levels and the pipeline-wide
//               chip-enable / flush / true levels.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IACC = 2'd1,
    ST_DACC = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // SRAM strobes are active-low
  localparam logic c_sram_assert   = 1'b0;
  localparam logic c_sram_deassert = 1'b1;

  // Core-wide logic levels
  localparam logic c_chip_enable = 1'b1;
  localparam logic c_flush       = 1'b1;
  localparam logic c_true_v      = 1'b1;

  // A data access is a write when any byte enable is set
  function automatic logic be_is_write(input logic [3:0] be);
    return |be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_ctr
// Description : Loadable down-counter with zero flag; times the SRAM wait
//               cycles of one access. Saturates at zero.
// Revision    : 1.0 - initial release
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               i_load     - load i_load_val (wins over decrement)
//               i_load_val - value to load
//               i_dec      - decrement by one when non-zero
//               o_zero     - count is zero
// ============================================================================
module sram_wait_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares the single off-chip SRAM port between the instruction
//               fetch port and the MEM-stage data port. Data has fixed
//               priority, every access lasts WAIT_CYCLES SRAM cycles followed
//               by a one-cycle DONE (ack) and an IDLE bubble. A fetch that is
//               flushed while in flight still completes on the SRAM, but its
//               ack is suppressed.
// Revision    : 1.0 - initial release
// Ports       : cpu_clk_50M / cpu_rst    - clock, sync active-high reset
//               i_req/i_addr/i_rdata/i_ack - fetch port
//               d_req/d_be/d_addr/d_wdata/d_rdata/d_ack - data port
//               flush                    - exception flush from CP0
//               stall_req                - pipeline stall request
//               sram_*                   - off-chip SRAM interface
// ============================================================================
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  // fetch port
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  // data port
  input  logic              d_req,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  // pipeline control
  input  logic              flush,
  output logic              stall_req,
  // SRAM
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int c_ctr_w = $clog2(WAIT_CYCLES) + 1;

  arb_state_e r_state;
  logic       r_grant_d;   // 1: current access belongs to the data port
  logic       r_kill;      // fetch in flight was flushed; drop its ack

  logic w_grant;
  logic w_in_access;
  logic w_ctr_zero;
  logic w_fetch_dead;

  // Data wins; a fetch is not started while a flush is being signalled
  assign w_grant     = (r_state == ST_IDLE) &&
                       (d_req || (i_req && (flush != c_flush)));
  assign w_in_access = (r_state == ST_IACC) || (r_state == ST_DACC);
  // A flush arriving on the last access cycle must also kill the ack
  assign w_fetch_dead = r_kill || (flush == c_flush);

  sram_wait_ctr #(
    .WIDTH (c_ctr_w)
  ) u_wait_ctr (
    .clk        (cpu_clk_50M),
    .rst        (cpu_rst),
    .i_load     (w_grant),
    .i_load_val (c_ctr_w'(WAIT_CYCLES - 1)),
    .i_dec      (w_in_access),
    .o_zero     (w_ctr_zero)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state    <= ST_IDLE;
      r_grant_d  <= 1'b0;
      r_kill     <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      sram_ce_n  <= c_sram_deassert;
      sram_oe_n  <= c_sram_deassert;
      sram_we_n  <= c_sram_deassert;
      sram_be_n  <= {4{c_sram_deassert}};
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      // acks are single-cycle pulses
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_grant_d  <= d_req;
            sram_addr  <= d_req ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
            sram_wdata <= d_wdata;
            sram_ce_n  <= c_sram_assert;
            if (d_req && be_is_write(d_be)) begin
              sram_we_n <= c_sram_assert;
              sram_oe_n <= c_sram_deassert;
              sram_be_n <= ~d_be;
            end else begin
              // fetches and loads read the whole word
              sram_oe_n <= c_sram_assert;
              sram_we_n <= c_sram_deassert;
              sram_be_n <= {4{c_sram_assert}};
            end
            r_state <= d_req ? ST_DACC : ST_IACC;
          end
        end

        ST_IACC, ST_DACC: begin
          if ((r_state == ST_IACC) && (flush == c_flush)) begin
            r_kill <= c_true_v;
          end
          if (w_ctr_zero) begin
            if (r_grant_d) begin
              d_rdata <= sram_rdata;
              d_ack   <= c_true_v;
            end else begin
              i_rdata <= sram_rdata;
              i_ack   <= !w_fetch_dead;
            end
            sram_ce_n <= c_sram_deassert;
            sram_oe_n <= c_sram_deassert;
            sram_we_n <= c_sram_deassert;
            sram_be_n <= {4{c_sram_deassert}};
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // never re-grant here: the just-acked request is still high
          r_kill  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_req = !cpu_rst && ((i_req && !i_ack) || (d_req && !d_ack));

  // Address bits outside the SRAM word range are intentionally ignored
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = &{1'b0, i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule
`default_nettype wire
